// File: rtl/imem_pkg.sv
// ============================================================================
// Module  : imem_pkg
// Brief   : Shared constants and response-entry type for the imem responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

  localparam int IMEM_WORD_OFS    = 2;
  localparam int IMEM_ADDR_W      = 32;
  localparam int IMEM_DATA_W      = 32;
  localparam int IMEM_DEPTH_WORDS = 256;
  localparam int IMEM_LATENCY     = 2;
  localparam int IMEM_QDEPTH      = 4;

  typedef struct packed {
    logic [IMEM_DATA_W-1:0] data;
    logic                   err;
`ifdef IMEM_RSP_ADDR_EN
    logic [IMEM_ADDR_W-1:0] addr;
`endif
  } imem_rsp_t;

  function automatic logic imem_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_if.sv
// ============================================================================
// Module  : imem_if
// Brief   : Fetch request/response and program-load bus; rsp_addr exists only
//           when IMEM_RSP_ADDR_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface imem_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              flush;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
`ifdef IMEM_RSP_ADDR_EN
  logic [ADDR_W-1:0] rsp_addr;
`endif

  modport master (
    output req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
`ifdef IMEM_RSP_ADDR_EN
    , rsp_addr
`endif
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
`ifdef IMEM_RSP_ADDR_EN
    , rsp_addr
`endif
  );

endinterface

`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
// ============================================================================
// Module  : imem_rsp_fifo
// Brief   : Synchronous FIFO of response entries with push/pop/flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int  DEPTH = IMEM_QDEPTH,
  parameter type T     = imem_rsp_t
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       push,
  input  wire T                           push_data,
  input  wire logic                       pop,
  input  wire logic                       flush,
  output      T                           head,
  output      logic [$clog2(DEPTH+1)-1:0] count,
  output      logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T             mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/imem_responder.sv
// ============================================================================
// Module  : imem_responder
// Brief   : Instruction memory with fixed-latency pipeline, response FIFO,
//           occupancy-based flow control and flush. Optional IMEM_RSP_ADDR_EN
//           echoes the request address on rsp_addr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W      = IMEM_ADDR_W,
  parameter int DATA_W      = IMEM_DATA_W,
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int LATENCY     = IMEM_LATENCY,
  parameter int QDEPTH      = IMEM_QDEPTH
) (
  input wire logic clk,
  input wire logic rst_n,
  imem_if.slave    bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CW    = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
`ifdef IMEM_RSP_ADDR_EN
    logic [ADDR_W-1:0] addr;
`endif
  } rsp_t;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [CW-1:0]     occ;
  logic              accept;
  logic              pop;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              rd_oor;
  logic              wr_oor;
  rsp_t              rd_entry;
  rsp_t              pipe_e [LATENCY];
  logic [LATENCY-1:0] pipe_v;
  rsp_t              head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              have_head;

  assign rd_idx = bus.req_addr[IMEM_WORD_OFS +: IDX_W];
  assign wr_idx = bus.wr_addr[IMEM_WORD_OFS +: IDX_W];

  generate
    if (ADDR_W > IMEM_WORD_OFS + IDX_W) begin : g_hi_bits
      assign rd_oor = |bus.req_addr[ADDR_W-1:IMEM_WORD_OFS+IDX_W];
      assign wr_oor = |bus.wr_addr[ADDR_W-1:IMEM_WORD_OFS+IDX_W];
    end else begin : g_no_hi_bits
      assign rd_oor = 1'b0;
      assign wr_oor = 1'b0;
    end
  endgenerate

  assign bus.req_ready = (occ < CW'(QDEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    rd_entry     = '0;
    rd_entry.err = imem_misaligned(bus.req_addr[1:0]) || rd_oor;
    if (!rd_entry.err) rd_entry.data = mem[rd_idx];
`ifdef IMEM_RSP_ADDR_EN
    rd_entry.addr = bus.req_addr;
`endif
  end

  // Read samples mem before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !wr_oor) mem[wr_idx] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_e[i] <= '0;
    end else begin
      pipe_v[0] <= accept;
      if (accept) pipe_e[0] <= rd_entry;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1] && !bus.flush;
        pipe_e[i] <= pipe_e[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 occ <= '0;
    else if (bus.flush)         occ <= accept ? CW'(1) : '0;
    else if (accept && !pop)    occ <= occ + CW'(1);
    else if (!accept && pop)    occ <= occ - CW'(1);
  end

  imem_rsp_fifo #(
    .DEPTH (QDEPTH),
    .T     (rsp_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_v[LATENCY-1]),
    .push_data (pipe_e[LATENCY-1]),
    .pop       (pop),
    .flush     (bus.flush),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign have_head     = (fifo_count != '0);
  assign bus.rsp_valid = !fifo_empty && !bus.flush;
  assign bus.rsp_data  = have_head ? head.data : '0;
  assign bus.rsp_err   = have_head ? head.err  : 1'b0;
`ifdef IMEM_RSP_ADDR_EN
  assign bus.rsp_addr  = have_head ? head.addr : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
// ============================================================================
// Module  : tb_imem_responder
// Brief   : Self-checking bench: vector table plus scoreboard of responses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .LATENCY(2), .QDEPTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  exp_t        sb[$];
  int          checks  = 0;
  int          passed  = 0;
  int          rsp_cnt = 0;
  int          acc_cnt = 0;
  logic [31:0] cur_data;
  logic        cur_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
  endtask

  // Inputs are settled at posedge+2; handshakes are evaluated before the edge.
  task automatic tick();
    exp_t e;
    #1;
    if (bus.rsp_valid && bus.rsp_ready) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rsp: got data 0x%08h, want no response", bus.rsp_data);
      end else begin
        e = sb.pop_front();
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
`ifdef IMEM_RSP_ADDR_EN
        check("rsp_addr", bus.rsp_addr, e.addr);
`endif
      end
    end
    if (bus.flush) sb.delete();
    if (bus.req_valid && bus.req_ready) begin
      acc_cnt++;
      e.data = cur_data;
      e.err  = cur_err;
      e.addr = bus.req_addr;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.wr_en     = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic er);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    cur_data      = d;
    cur_err       = er;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && sb.size() > 0; i++) begin
      idle();
      tick();
    end
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL %s: got %0d outstanding, want 0", name, sb.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    vec_t        bp[6];
    logic [31:0] ld_a[7];
    logic [31:0] ld_d[7];
    int          base;

    vecs[0] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h0050_0093, 1'b0};
    vecs[2] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_0400, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0008, 32'hAAAA_0008, 1'b0};
    vecs[5] = '{32'h0000_000C, 32'h0000_C00C, 1'b0};
    vecs[6] = '{32'h0000_03FC, 32'h0FF0_FF00, 1'b0};
    vecs[7] = '{32'h0000_0401, 32'h0000_0000, 1'b1};

    ld_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h3FC, 32'h400};
    ld_d = '{32'h0000_0013, 32'h0050_0093, 32'hAAAA_0008, 32'h0000_C00C,
             32'h1111_1111, 32'h0FF0_FF00, 32'hBAD0_BAD0};

    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
    bus.flush = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    cur_data = '0; cur_err = 1'b0;

    // Reset state
    #12;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Program load; the last write is out of range and must not alias word 0
    for (int i = 0; i < 7; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = ld_a[i]; bus.wr_data = ld_d[i];
      tick();
    end
    idle();

    // Latency: accept at edge t, response visible after t+2 and t+3
    bus.rsp_ready = 1'b1;
    req(32'h0, 32'h0000_0013, 1'b0); tick();
    req(32'h4, 32'h0050_0093, 1'b0); tick();
    check("lat_t1_valid", 32'(bus.rsp_valid), 32'd0);
    idle(); tick();
    check("lat_t2_valid", 32'(bus.rsp_valid), 32'd1);
    tick();
    check("lat_t3_valid", 32'(bus.rsp_valid), 32'd1);
    tick();
    check("lat_done_valid", 32'(bus.rsp_valid), 32'd0);
    drain("lat_drain");

    // Vector table back-to-back, full throughput
    for (int i = 0; i < 8; i++) begin
      req(vecs[i].addr, vecs[i].data, vecs[i].err);
      check("tput_req_ready", 32'(bus.req_ready), 32'd1);
      tick();
    end
    drain("vec_drain");

    // Backpressure: only QDEPTH accepted, head held stable
    bp[0] = '{32'h0, 32'h0000_0013, 1'b0};
    bp[1] = '{32'h4, 32'h0050_0093, 1'b0};
    bp[2] = '{32'h8, 32'hAAAA_0008, 1'b0};
    bp[3] = '{32'hC, 32'h0000_C00C, 1'b0};
    bp[4] = '{32'h0, 32'h0000_0013, 1'b0};
    bp[5] = '{32'h4, 32'h0050_0093, 1'b0};
    bus.rsp_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      req(bp[i].addr, bp[i].data, bp[i].err);
      tick();
    end
    idle();
    check("bp_accepted", 32'(acc_cnt), 32'd4);
    check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_hold_data0", bus.rsp_data, 32'h0000_0013);
    tick(); tick(); tick();
    check("bp_hold_data1", bus.rsp_data, 32'h0000_0013);
    bus.rsp_ready = 1'b1;
    base = rsp_cnt;
    drain("bp_drain");
    check("bp_rsp_count", 32'(rsp_cnt - base), 32'd4);
    check("bp_req_ready_after", 32'(bus.req_ready), 32'd1);

    // Flush with a redirected fetch in the same cycle
    bus.rsp_ready = 1'b0;
    req(32'h0, 32'h0000_0013, 1'b0); tick();
    req(32'h4, 32'h0050_0093, 1'b0); tick();
    req(32'hC, 32'h0000_C00C, 1'b0); tick();
    req(32'h8, 32'hAAAA_0008, 1'b0);
    bus.flush = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    check("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    base = rsp_cnt;
    tick();
    idle();
    for (int i = 0; i < 8; i++) tick();
    check("flush_rsp_count", 32'(rsp_cnt - base), 32'd1);
    check("flush_sb_empty", 32'(sb.size()), 32'd0);

    // Read and write of the same word in one cycle
    req(32'h10, 32'h1111_1111, 1'b0);
    bus.wr_en = 1'b1; bus.wr_addr = 32'h10; bus.wr_data = 32'hDEAD_BEEF;
    tick();
    bus.wr_en = 1'b0;
    req(32'h10, 32'hDEAD_BEEF, 1'b0);
    tick();
    drain("rw_drain");

    // Asynchronous reset with outstanding fetches
    bus.rsp_ready = 1'b0;
    req(32'h0, 32'h0000_0013, 1'b0); tick();
    req(32'h4, 32'h0050_0093, 1'b0); tick();
    idle(); tick();
    check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_data", bus.rsp_data, 32'd0);
    sb.delete();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b1;
    base = rsp_cnt;
    for (int i = 0; i < 8; i++) tick();
    check("post_rst_no_rsp", 32'(rsp_cnt - base), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
